// File: rtl/cache_ram_arbiter.sv
// Arbiter sharing one RAM port between the icache and the dcache.
// Dcache wins ties; a run counter hands the port to a waiting icache after MAX_DRUN dcache words.
module cache_ram_arbiter #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned MAX_DRUN = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;
    localparam logic [3:0] DrunMax   = 4'(MAX_DRUN);

    typedef enum logic [1:0] {StIdle, StIgnt, StDgnt} state_e;

    state_e     state_q, state_d;
    logic [3:0] drun_q, drun_d;
    logic       ram_err_q, ram_err_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            drun_q    <= 4'd0;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drun_q    <= drun_d;
            ram_err_q <= ram_err_d;
        end
    end

    assign ram_err = ram_err_q;

    always_comb begin
        state_d   = state_q;
        drun_d    = drun_q;
        ram_err_d = ram_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        case (state_q)
            StIdle: begin
                if ((dREN || dWEN) && !(iREN && drun_q == DrunMax)) begin
                    state_d = StDgnt;
                end else if (iREN) begin
                    state_d = StIgnt;
                end
            end

            StIgnt: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramstate == RamError) begin
                    ram_err_d = 1'b1;
                end
                if (ramstate == RamAccess) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = StIdle;
                    drun_d  = 4'd0;
                end else if (!iREN) begin
                    state_d = StIdle;
                end
            end

            StDgnt: begin
                ramaddr  = daddr;
                ramstore = dstore;
                // A simultaneous read and write request is served as the write.
                if (dWEN) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
                if (ramstate == RamError) begin
                    ram_err_d = 1'b1;
                end
                if (ramstate == RamAccess) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = StIdle;
                    if (!iREN) begin
                        drun_d = 4'd0;
                    end else if (drun_q < DrunMax) begin
                        drun_d = drun_q + 4'd1;
                    end
                end else if (!dREN && !dWEN) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Directed bench for cache_ram_arbiter: reset, single grants, priority, fairness, errors.
module tb_cache_ram_arbiter;

    localparam int unsigned WORD_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ram_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cache_ram_arbiter #(.WORD_W(WORD_W), .MAX_DRUN(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = '0; daddr = 32'h80; dstore = '0; ramload = '0; ramstate = 2'd0;

        // Reset held with both requests pending
        tick(); tick();
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ram_err", ram_err, 0);
        nRST = 1'b1;
        tick();
        chk("rst_dgnt_ramREN", ramREN, 1);
        chk("rst_dgnt_ramaddr", ramaddr, 32'h80);
        chk("rst_dgnt_iwait", iwait, 1);
        iREN = 1'b0; dREN = 1'b0;
        #1 chk("wd_dwait", dwait, 1);
        tick();
        chk("wd_idle_ramREN", ramREN, 0);

        // Icache read: two BUSY cycles then ACCESS
        iREN = 1'b1; iaddr = 32'h100; ramstate = 2'd1;
        #1 chk("ird_bubble_ramREN", ramREN, 0);
        tick();
        chk("ird_c1_ramREN", ramREN, 1);
        chk("ird_c1_ramaddr", ramaddr, 32'h100);
        chk("ird_c1_iwait", iwait, 1);
        chk("ird_c1_iload", iload, 0);
        tick();
        chk("ird_c2_ramREN", ramREN, 1);
        chk("ird_c2_iwait", iwait, 1);
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #1;
        chk("ird_acc_iwait", iwait, 0);
        chk("ird_acc_iload", iload, 32'hDEADBEEF);
        chk("ird_acc_dload", dload, 0);
        chk("ird_acc_dwait", dwait, 1);
        tick();
        iREN = 1'b0; ramstate = 2'd0;
        #1;
        chk("ird_idle_ramREN", ramREN, 0);
        chk("ird_idle_iwait", iwait, 1);
        chk("ird_idle_iload", iload, 0);
        tick();

        // Simultaneous requests: dcache write first, then icache
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
        tick();
        chk("sim_d_ramWEN", ramWEN, 1);
        chk("sim_d_ramREN", ramREN, 0);
        chk("sim_d_ramstore", ramstore, 32'h1234);
        chk("sim_d_ramaddr", ramaddr, 32'h200);
        ramstate = 2'd2;
        #1;
        chk("sim_d_dwait", dwait, 0);
        chk("sim_d_iwait", iwait, 1);
        tick();
        dWEN = 1'b0; ramstate = 2'd0;
        #1;
        chk("sim_idle_ramWEN", ramWEN, 0);
        chk("sim_idle_ramREN", ramREN, 0);
        tick();
        chk("sim_i_ramREN", ramREN, 1);
        chk("sim_i_ramaddr", ramaddr, 32'h100);
        chk("sim_i_ramstore", ramstore, 0);
        ramstate = 2'd2; ramload = 32'h55;
        #1;
        chk("sim_i_iload", iload, 32'h55);
        chk("sim_i_iwait", iwait, 0);
        tick();
        iREN = 1'b0; ramstate = 2'd0;
        tick();

        // Starvation guard: completions alternate with IDLE bubbles as D D D D I D
        dREN = 1'b1; iREN = 1'b1; ramstate = 2'd2; ramload = 32'hA5A5;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("fair_dwait_%0d", k), dwait, ((k % 2 == 1) && k != 9) ? 0 : 1);
            chk($sformatf("fair_iwait_%0d", k), iwait, (k == 9) ? 0 : 1);
        end
        chk("fair_dload", dload, 32'hA5A5);
        dREN = 1'b0; iREN = 1'b0; ramstate = 2'd0;
        tick();

        // Read+write collision, write dropped mid-grant, then full withdrawal
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hAA; ramstate = 2'd1;
        tick();
        chk("rw_ramWEN", ramWEN, 1);
        chk("rw_ramREN", ramREN, 0);
        dWEN = 1'b0;
        #1;
        chk("rw_rd_ramREN", ramREN, 1);
        chk("rw_rd_ramWEN", ramWEN, 0);
        chk("rw_rd_ramaddr", ramaddr, 32'h300);
        tick();
        chk("rw_hold_ramREN", ramREN, 1);
        dREN = 1'b0;
        #1 chk("rw_wd_dwait", dwait, 1);
        tick();
        chk("rw_idle_ramREN", ramREN, 0);
        chk("rw_idle_dwait", dwait, 1);

        // ERROR during an icache grant, completion still delivered
        iREN = 1'b1; iaddr = 32'h400; ramstate = 2'd3;
        tick();
        chk("err_pre_ram_err", ram_err, 0);
        tick();
        chk("err_set_ram_err", ram_err, 1);
        chk("err_hold_ramREN", ramREN, 1);
        chk("err_hold_iwait", iwait, 1);
        tick();
        ramstate = 2'd2; ramload = 32'h77;
        #1;
        chk("err_acc_iwait", iwait, 0);
        chk("err_acc_iload", iload, 32'h77);
        tick();
        iREN = 1'b0; ramstate = 2'd0;
        #1 chk("err_sticky", ram_err, 1);
        tick();

        // Asynchronous reset in the middle of a dcache write
        dWEN = 1'b1; daddr = 32'h500; ramstate = 2'd1;
        tick();
        chk("arst_pre_ramWEN", ramWEN, 1);
        nRST = 1'b0;
        #1;
        chk("arst_ramWEN", ramWEN, 0);
        chk("arst_ram_err", ram_err, 0);
        chk("arst_dwait", dwait, 1);
        dWEN = 1'b0;
        nRST = 1'b1;
        tick();
        chk("arst_after_ramWEN", ramWEN, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ram_arbiter.md
Name: cache_ram_arbiter

Overview:
- Shares the single RAM port between the instruction cache and the data cache of the pipelined datapath.
- Each word transaction is granted to one cache, held until RAM reports ACCESS, then released.
- Dcache has priority; a fairness counter prevents icache starvation during long dcache bursts.
- Wait outputs feed the caches; the caches in turn drive the dhit/ihit inputs of the hazard logic.

Parameters:
- WORD_W, 32, data/address width in bits.
- MAX_DRUN, 4, max consecutive dcache grants while icache is pending (1..15).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iwait  out  1  1 = icache must keep waiting
- iload  out  WORD_W  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache word address
- dstore  in  WORD_W  dcache write data
- dwait  out  1  1 = dcache must keep waiting
- dload  out  WORD_W  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ram_err  out  1  sticky: ERROR seen during a grant

Behaviour:
- FSM states: IDLE, IGNT, DGNT. Registers: state, drun (4 bits), ram_err.
- Reset (nRST low, async): state=IDLE, drun=0, ram_err=0. A reset mid-transaction aborts it: ramREN/ramWEN drop immediately, no data is returned.
- IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0.
- IDLE, next-state selection in priority order:
  - (dREN|dWEN) and not (iREN and drun==MAX_DRUN) -> DGNT.
  - else iREN -> IGNT.
  - else stay in IDLE.
- One-cycle arbitration bubble: a request first seen in IDLE is driven to RAM on the following cycle.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN set: ramWEN=1, ramREN=0. dREN and dWEN both set: the write wins.
  - Otherwise ramREN=1.
- IGNT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: the cycle ramstate==ACCESS while granted.
  - The granted wait goes 0 combinationally.
  - The granted load output = ramload.
  - Next state is IDLE.
- Loads: the non-granted load output is 0, and iload/dload are 0 whenever not completing.
- iwait = ~(state==IGNT & ramstate==ACCESS). dwait = ~(state==DGNT & ramstate==ACCESS). Both are 1 in reset/IDLE.
- ramstate BUSY or FREE while granted: hold the grant and all RAM outputs stable.
- ramstate ERROR while granted: set ram_err (cleared only by reset). Hold the grant; this is treated as BUSY.
- Request withdrawn while granted (the granted cache's REN/WEN both low): return to IDLE next cycle with no completion. drun is not changed.
- drun update on each dcache completion:
  - iREN high: drun = drun+1, saturating at MAX_DRUN.
  - iREN low: drun = 0.
- drun is cleared on each icache completion.
- Consequence: after MAX_DRUN back-to-back dcache completions with iREN pending, the next grant goes to icache.
- No combinational path from ramload to any output other than iload/dload, and none to ram* outputs.

Test Plan:
- Reset: hold nRST=0 with iREN=dREN=1. Required: iwait=dwait=1, ramREN=ramWEN=0, ram_err=0. Release nRST -> DGNT on the next edge.
- Icache read: iREN=1, iaddr=0x100, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF. Required: ramREN=1, ramaddr=0x100 from cycle 1; iload=0xDEADBEEF and iwait=0 only in the ACCESS cycle; IDLE afterwards.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x200, dstore=0x1234. Required: DGNT first with ramWEN=1, ramstore=0x1234; after dwait pulses low, IGNT after one IDLE cycle.
- Starvation: MAX_DRUN=4, dREN and iREN held high, every grant completes in 1 cycle. Required: exactly 4 dcache completions, then 1 icache completion, then dcache again.
- dREN=dWEN=1: ramWEN=1, ramREN=0. Drop dWEN mid-grant while dREN stays high: switches to a read of the same address. Drop both: IDLE next cycle, dwait stays 1.
- ERROR, then reset: ramstate=ERROR for 2 cycles during IGNT, then ACCESS. Required: ram_err=1 and stays 1, completion still delivered. Assert nRST mid-DGNT: ramWEN drops asynchronously and ram_err=0.
